// File: rtl/img_window_streamer_pkg.sv
// Shared types for the frame loader / 3x3 window streamer.
// Pure declarations; no logic, no latency. ZERO_PAD_EN is consumed by the RTL files.
package img_proc_pkg;

  localparam int IMG_DIM_DEF    = 20;
  localparam int BIT_LENGTH_DEF = 5;

  typedef logic [BIT_LENGTH_DEF-1:0] pixel_t;

  typedef enum logic {
    LOAD = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Tap numbering is row-major over the 3x3 neighbourhood.
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

endpackage

// File: rtl/img_window_streamer_if.sv
// Pixel-in / window-out handshake bundle for img_window_streamer.
// Wires only; slave = block side, master = producer/consumer side.
interface img_window_streamer_if #(
  parameter int IMG_DIM     = 20,
  parameter int BIT_LENGTH  = 5,
  parameter int PIX_PER_CYC = 3
) ();

  localparam int RW = $clog2(IMG_DIM);

  logic                              in_valid;
  logic                              in_ready;
  logic [PIX_PER_CYC*BIT_LENGTH-1:0] in_pixels;
  logic                              out_valid;
  logic                              out_ready;
  logic [9*BIT_LENGTH-1:0]           out_win;
  logic [RW-1:0]                     out_row;
  logic [RW-1:0]                     out_col;
  logic                              out_last;

  modport slave (
    input  in_valid, in_pixels, out_ready,
    output in_ready, out_valid, out_win, out_row, out_col, out_last
  );

  modport master (
    output in_valid, in_pixels, out_ready,
    input  in_ready, out_valid, out_win, out_row, out_col, out_last
  );

endinterface

// File: rtl/img_window_streamer_frame_store.sv
// IMG_DIM^2 pixel register file: P-lane write port, 9 combinational taps around a centre.
// Write lands on the next clock edge; reads are zero-latency. No backpressure.
// ZERO_PAD_EN: taps falling outside the frame read as zero.
module img_frame_store
  import img_proc_pkg::*;
#(
  parameter int IMG_DIM     = IMG_DIM_DEF,
  parameter int BIT_LENGTH  = BIT_LENGTH_DEF,
  parameter int PIX_PER_CYC = 3,
  parameter int WA          = $clog2(IMG_DIM*IMG_DIM + PIX_PER_CYC),
  parameter int RW          = $clog2(IMG_DIM)
) (
  input  logic                              clk,
  input  logic [PIX_PER_CYC-1:0]            wr_en,
  input  logic [WA-1:0]                     wr_addr,
  input  logic [PIX_PER_CYC*BIT_LENGTH-1:0] wr_data,
  input  logic [RW-1:0]                     rd_row,
  input  logic [RW-1:0]                     rd_col,
  output logic [9*BIT_LENGTH-1:0]           rd_taps
);

  localparam int N  = IMG_DIM*IMG_DIM;
  localparam int AW = $clog2(N);

  logic [BIT_LENGTH-1:0] mem_q [N];
  logic [BIT_LENGTH-1:0] mem_d [N];

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < PIX_PER_CYC; k++) begin
      if (wr_en[k]) begin
        mem_d[AW'(wr_addr + WA'(k))] = wr_data[k*BIT_LENGTH +: BIT_LENGTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    int r;
    int c;
    r       = 0;
    c       = 0;
    rd_taps = '0;
    for (int t = TAP_TL; t <= TAP_BR; t++) begin
      r = int'(rd_row) + (t / 3) - (TAP_C / 3);
      c = int'(rd_col) + (t % 3) - (TAP_C % 3);
`ifdef ZERO_PAD_EN
      if (r >= 0 && r < IMG_DIM && c >= 0 && c < IMG_DIM) begin
        rd_taps[t*BIT_LENGTH +: BIT_LENGTH] = mem_q[AW'(r*IMG_DIM + c)];
      end
`else
      // Centres never touch the border here, so every tap is in range.
      rd_taps[t*BIT_LENGTH +: BIT_LENGTH] = mem_q[AW'(r*IMG_DIM + c)];
`endif
    end
  end

endmodule

// File: rtl/img_window_streamer.sv
// Loads an IMG_DIM^2 frame, then streams one 3x3 window per handshake in raster order (ZERO_PAD_EN: padded borders).
// Latency: first window valid the cycle after the last input beat is accepted.
// Backpressure: out_ready low holds the current window; in_ready is low for the whole scan.
module img_window_streamer
  import img_proc_pkg::*;
#(
  parameter int IMG_DIM     = IMG_DIM_DEF,
  parameter int BIT_LENGTH  = BIT_LENGTH_DEF,
  parameter int PIX_PER_CYC = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  img_window_streamer_if.slave bus
);

  localparam int N  = IMG_DIM*IMG_DIM;
  localparam int WA = $clog2(N + PIX_PER_CYC);
  localparam int RW = $clog2(IMG_DIM);
`ifdef ZERO_PAD_EN
  localparam int FIRST = 0;
  localparam int LAST  = IMG_DIM - 1;
`else
  localparam int FIRST = 1;
  localparam int LAST  = IMG_DIM - 2;
`endif
  localparam logic [RW-1:0] FIRST_C = RW'(FIRST);
  localparam logic [RW-1:0] LAST_C  = RW'(LAST);

  state_t                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [WA-1:0]          addr_q, addr_d;
  logic [RW-1:0]          row_q, row_d;
  logic [RW-1:0]          col_q, col_d;
  logic [PIX_PER_CYC-1:0] wr_en;
  logic                   in_fire;
  logic                   out_fire;

  always_comb begin
    in_fire     = bus.in_valid && in_ready_q;
    out_fire    = out_valid_q && bus.out_ready;
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    addr_d      = addr_q;
    row_d       = row_q;
    col_d       = col_q;

    // Lanes past the final pixel of the last beat are dropped.
    for (int k = 0; k < PIX_PER_CYC; k++) begin
      wr_en[k] = in_fire && ((addr_q + WA'(k)) < WA'(N));
    end

    case (state_q)
      LOAD: begin
        if (in_fire) begin
          if ((addr_q + WA'(PIX_PER_CYC)) >= WA'(N)) begin
            state_d     = SCAN;
            addr_d      = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            row_d       = FIRST_C;
            col_d       = FIRST_C;
            out_last_d  = (FIRST == LAST);
          end else begin
            addr_d = addr_q + WA'(PIX_PER_CYC);
          end
        end
      end
      SCAN: begin
        if (out_fire) begin
          if (out_last_q) begin
            state_d     = LOAD;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            row_d       = FIRST_C;
            col_d       = FIRST_C;
          end else begin
            if (col_q == LAST_C) begin
              col_d = FIRST_C;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + RW'(1);
            end
            out_last_d = (row_d == LAST_C) && (col_d == LAST_C);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      addr_q      <= '0;
      row_q       <= FIRST_C;
      col_q       <= FIRST_C;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  img_frame_store #(
    .IMG_DIM     (IMG_DIM),
    .BIT_LENGTH  (BIT_LENGTH),
    .PIX_PER_CYC (PIX_PER_CYC),
    .WA          (WA),
    .RW          (RW)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (addr_q),
    .wr_data (bus.in_pixels),
    .rd_row  (row_q),
    .rd_col  (col_q),
    .rd_taps (bus.out_win)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;

endmodule
